// File: rtl/bist_response_analyzer.sv
// SRAM BIST response analyzer: aligns expected data with read latency,
// counts mismatches and captures the first failing read.
module bist_response_analyzer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 4,
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 we,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic                 last,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_valid,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_fail_addr,
  output logic [DATA_W-1:0]    first_fail_exp,
  output logic [DATA_W-1:0]    first_fail_act
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] adr_q, adr_d;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_q, exp_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic [DATA_W-1:0] ffe_q, ffe_d;
  logic [DATA_W-1:0] ffx_q, ffx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic ev_q, ev_d;
  logic hit;

  assign hit = vld_q[RD_LAT-1] &&
               (rd_data != exp_q[RD_LAT-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ffa_d   = ffa_q;
    ffe_d   = ffe_q;
    ffx_d   = ffx_q;
    done_d  = done_q;
    pass_d  = pass_q;
    ev_d    = 1'b0;
    vld_d   = vld_q;
    adr_d   = adr_q;
    exp_d   = exp_q;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = adr_q[i-1];
      exp_d[i] = exp_q[i-1];
    end
    vld_d[0] = (state_q == S_RUN) && !we;
    adr_d[0] = addr;
    exp_d[0] = exp_data;
    if (hit) begin
      ev_d = 1'b1;
      if (cnt_q != {ERR_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (cnt_q == '0) begin
        ffa_d = adr_q[RD_LAT-1];
        ffe_d = exp_q[RD_LAT-1];
        ffx_d = rd_data;
      end
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ffa_d   = '0;
          ffe_d   = '0;
          ffx_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          ev_d    = 1'b0;
          vld_d   = '0;
          adr_d   = '0;
          exp_d   = '0;
        end
      end
      S_RUN: begin
        if (last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // finish once the last in-flight read has been compared
        if (vld_d == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      adr_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      ffa_q   <= '0;
      ffe_q   <= '0;
      ffx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      adr_q   <= adr_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      ffa_q   <= ffa_d;
      ffe_q   <= ffe_d;
      ffx_q   <= ffx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ev_q    <= ev_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_valid       = ev_q;
  assign err_count       = cnt_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_exp  = ffe_q;
  assign first_fail_act  = ffx_q;

endmodule
